fmmu_test_1: RTL and testbench
==============================

Name: fmmu_test_1

Overview:
Single-channel EtherCAT FMMU (fieldbus memory management unit) address mapper. It compares the logical window of an incoming datagram against one configured FMMU logical window. On overlap, it produces the local physical (bus) start address, the number of mapped bytes, and the byte offset inside the datagram. It sits between the frame-processing unit and the ESC local memory bus.

Parameters:
- LOG_AW, 32, logical address width (sub_address, fmmu_logic_address_start)
- PHY_AW, 16, physical/bus address width
- LEN_W, 8, length field width (sub_len, fmmu_logic_length, outputs)

Ports:
- clk  input  1  system clock, rising edge
- RSTN  input  1  asynchronous active-low reset
- sub_address  input  32  logical start address of current datagram
- sub_len  input  8  datagram data length in bytes
- subdv  input  1  datagram descriptor valid; inputs sampled only when high
- fmmu_physical_address_start  input  16  physical start of FMMU window
- fmmu_logic_address_start  input  32  logical start of FMMU window
- fmmu_logic_length  input  8  FMMU window length in bytes
- bus_address  output  16  physical address of first mapped byte
- fmmu_map_address_len  output  8  number of mapped bytes (0 = no hit)
- fmmu_frame_offset  output  8  offset of first mapped byte within datagram data
- map_dv  output  1  registered result valid

Behaviour:
- Reset (RSTN low, asynchronous): all outputs = 0; held until RSTN is released.
- All outputs are registered. Latency is 1 clk: inputs sampled on rising edge N with subdv=1 produce results after edge N.
- subdv=0 at an edge: map_dv=0, bus_address=0, fmmu_map_address_len=0, fmmu_frame_offset=0 on the next cycle.
- subdv=1 at an edge: map_dv=1 and the result is computed as follows:
  - S=sub_address, SE=S+sub_len; L=fmmu_logic_address_start, LE=L+fmmu_logic_length. All sums are computed 33-bit, with no wrap, so windows ending at or beyond 2^32 compare correctly.
  - Intervals are half-open: [S,SE) and [L,LE).
  - Hit iff sub_len!=0 and fmmu_logic_length!=0 and S<LE and L<SE.
  - Hit: lo=max(S,L), hi=min(SE,LE).
    - fmmu_map_address_len=hi-lo.
    - bus_address=fmmu_physical_address_start+(lo-L), truncated mod 2^16.
    - fmmu_frame_offset=lo-S.
  - Miss: bus_address=0, fmmu_map_address_len=0, fmmu_frame_offset=0. map_dv is still 1, so a valid miss is indicated by len=0.
- Adjacent windows (SE==L or LE==S) are a miss.
- Configuration inputs may change every cycle; no internal storage of configuration.
- Back-to-back subdv cycles each produce an independent result; no throughput limit.
- Purely combinational compare path plus one output register stage. No FSM.

Optional Feature:
- Macro FMMU_HIT_FLAG_EN.
  - Defined: adds output port map_hit (1 bit, reset 0). It is registered alongside the other outputs and is 1 only when subdv was 1 and the hit condition held.
  - Undefined: no map_hit port; a hit is inferred from fmmu_map_address_len!=0.

Test Plan:
- Config for all scenarios: L=0x14141414, fmmu_logic_length=2, phys=0x1001.
- Scenario 1, reset and idle: RSTN low, then subdv=0 -> all outputs 0, map_dv=0.
- Scenario 2, misses, each with subdv=1:
  - S=0x10000000, len=1 -> map_dv=1, len=0, bus=0.
  - S=0x14141416, len=1 (adjacent end) -> len=0.
- Scenario 3, partial overlaps:
  - S=0x14141413, len=2 -> bus=0x1001, len=1, offset=1.
  - S=0x14141415, len=4 -> bus=0x1002, len=1, offset=0.
- Scenario 4, exact and superset:
  - S=0x14141414, len=1 -> bus=0x1001, len=1, offset=0.
  - S=0x14141412, len=8 -> bus=0x1001, len=2, offset=2.
- Scenario 5, zero lengths and wrap:
  - sub_len=0 -> miss.
  - L=0xFFFFFFFF, fmmu_logic_length=2, S=0xFFFFFFFF, len=1 -> hit, len=1.
  - phys=0xFFFF with S=L+1 and fmmu_logic_length=2 -> bus=0x0000.
- Scenario 6, timing and reset: assert RSTN low mid-stream with subdv=1 -> outputs clear immediately (asynchronously). After release, the first result appears exactly one clk after its sampling edge; subdv dropping yields map_dv=0 on the next cycle.

Source files
------------

// File: rtl/fmmu_test_1.sv
// Single-channel EtherCAT FMMU address mapper: one registered stage mapping a datagram's logical window onto a local bus window.
// Optional FMMU_HIT_FLAG_EN adds a registered map_hit output; without it a hit is signalled by a non-zero fmmu_map_address_len.
module fmmu_test_1 #(
    parameter int LOG_AW = 32,
    parameter int PHY_AW = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              RSTN,
    input  logic [LOG_AW-1:0] sub_address,
    input  logic [LEN_W-1:0]  sub_len,
    input  logic              subdv,
    input  logic [PHY_AW-1:0] fmmu_physical_address_start,
    input  logic [LOG_AW-1:0] fmmu_logic_address_start,
    input  logic [LEN_W-1:0]  fmmu_logic_length,
    output logic [PHY_AW-1:0] bus_address,
    output logic [LEN_W-1:0]  fmmu_map_address_len,
    output logic [LEN_W-1:0]  fmmu_frame_offset,
`ifdef FMMU_HIT_FLAG_EN
    output logic              map_hit,
`endif
    output logic              map_dv
);

    // One extra bit so window ends at or past 2^LOG_AW never wrap into a false overlap.
    localparam int EW = LOG_AW + 1;

    logic [EW-1:0]     s_lo, s_hi, l_lo, l_hi;
    logic [EW-1:0]     lo, hi;
    logic              hit;
    logic [PHY_AW-1:0] bus_nxt;
    logic [LEN_W-1:0]  len_nxt, off_nxt;

    always_comb begin
        s_lo = {1'b0, sub_address};
        s_hi = s_lo + EW'(sub_len);
        l_lo = {1'b0, fmmu_logic_address_start};
        l_hi = l_lo + EW'(fmmu_logic_length);

        // Half-open intervals: touching ends are not an overlap.
        hit = (sub_len != '0) && (fmmu_logic_length != '0) &&
              (s_lo < l_hi) && (l_lo < s_hi);

        lo = (s_lo >= l_lo) ? s_lo : l_lo;
        hi = (s_hi <= l_hi) ? s_hi : l_hi;

        bus_nxt = '0;
        len_nxt = '0;
        off_nxt = '0;
        if (hit) begin
            len_nxt = LEN_W'(hi - lo);
            off_nxt = LEN_W'(lo - s_lo);
            bus_nxt = fmmu_physical_address_start + PHY_AW'(lo - l_lo);
        end
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            map_dv               <= 1'b0;
            bus_address          <= '0;
            fmmu_map_address_len <= '0;
            fmmu_frame_offset    <= '0;
`ifdef FMMU_HIT_FLAG_EN
            map_hit              <= 1'b0;
`endif
        end else begin
            map_dv <= subdv;
            if (subdv) begin
                bus_address          <= bus_nxt;
                fmmu_map_address_len <= len_nxt;
                fmmu_frame_offset    <= off_nxt;
`ifdef FMMU_HIT_FLAG_EN
                map_hit              <= hit;
`endif
            end else begin
                bus_address          <= '0;
                fmmu_map_address_len <= '0;
                fmmu_frame_offset    <= '0;
`ifdef FMMU_HIT_FLAG_EN
                map_hit              <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fmmu_test_1.sv
// Scoreboard bench for fmmu_test_1: directed plan vectors plus random traffic against a byte-walking reference model.
module tb_fmmu_test_1;

    logic        clk = 1'b0;
    logic        RSTN = 1'b0;
    logic [31:0] sub_address = '0;
    logic [7:0]  sub_len = '0;
    logic        subdv = 1'b0;
    logic [15:0] fmmu_physical_address_start = '0;
    logic [31:0] fmmu_logic_address_start = '0;
    logic [7:0]  fmmu_logic_length = '0;
    logic [15:0] bus_address;
    logic [7:0]  fmmu_map_address_len;
    logic [7:0]  fmmu_frame_offset;
    logic        map_dv;
`ifdef FMMU_HIT_FLAG_EN
    logic        map_hit;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        dv;
        logic [15:0] bus;
        logic [7:0]  len;
        logic [7:0]  off;
        logic        hit;
    } exp_t;

    exp_t sb[$];

    fmmu_test_1 dut (
        .clk                         (clk),
        .RSTN                        (RSTN),
        .sub_address                 (sub_address),
        .sub_len                     (sub_len),
        .subdv                       (subdv),
        .fmmu_physical_address_start (fmmu_physical_address_start),
        .fmmu_logic_address_start    (fmmu_logic_address_start),
        .fmmu_logic_length           (fmmu_logic_length),
        .bus_address                 (bus_address),
        .fmmu_map_address_len        (fmmu_map_address_len),
        .fmmu_frame_offset           (fmmu_frame_offset),
`ifdef FMMU_HIT_FLAG_EN
        .map_hit                     (map_hit),
`endif
        .map_dv                      (map_dv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: walk every datagram byte and test membership in the FMMU window.
    function automatic exp_t model(input logic dv, input logic [31:0] s, input logic [7:0] sl,
                                   input logic [31:0] l, input logic [7:0] ll, input logic [15:0] p);
        exp_t   e;
        int     cnt;
        int     first;
        longint a, d;
        e = '{dv: dv, bus: 16'h0, len: 8'h0, off: 8'h0, hit: 1'b0};
        cnt = 0;
        first = 0;
        if (!dv) return e;
        for (int i = 0; i < int'(sl); i++) begin
            a = longint'(s) + longint'(i);
            if (a >= longint'(l) && a < longint'(l) + longint'(ll)) begin
                if (cnt == 0) first = i;
                cnt++;
            end
        end
        if (cnt > 0) begin
            d = longint'(s) + longint'(first) - longint'(l);
            e.len = 8'(cnt);
            e.off = 8'(first);
            e.bus = p + d[15:0];
            e.hit = 1'b1;
        end
        return e;
    endfunction

    task automatic apply(input logic dv, input logic [31:0] s, input logic [7:0] sl,
                         input logic [31:0] l, input logic [7:0] ll, input logic [15:0] p);
        @(negedge clk);
        subdv = dv;
        sub_address = s;
        sub_len = sl;
        fmmu_logic_address_start = l;
        fmmu_logic_length = ll;
        fmmu_physical_address_start = p;
    endtask

    task automatic drive_m(input logic dv, input logic [31:0] s, input logic [7:0] sl,
                           input logic [31:0] l, input logic [7:0] ll, input logic [15:0] p);
        apply(dv, s, sl, l, ll, p);
        sb.push_back(model(dv, s, sl, l, ll, p));
    endtask

    // Directed vectors carry hand-derived expectations rather than the model's.
    task automatic drive_k(input logic [31:0] s, input logic [7:0] sl, input logic [31:0] l,
                           input logic [7:0] ll, input logic [15:0] p,
                           input logic [15:0] ebus, input logic [7:0] elen, input logic [7:0] eoff);
        exp_t e;
        apply(1'b1, s, sl, l, ll, p);
        e = '{dv: 1'b1, bus: ebus, len: elen, off: eoff, hit: (elen != 8'h0)};
        sb.push_back(e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".dv"},  32'(map_dv), 32'h0);
        chk({tag, ".bus"}, 32'(bus_address), 32'h0);
        chk({tag, ".len"}, 32'(fmmu_map_address_len), 32'h0);
        chk({tag, ".off"}, 32'(fmmu_frame_offset), 32'h0);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (RSTN && sb.size() > 0) begin
            e = sb.pop_front();
            chk("map_dv", 32'(map_dv), 32'(e.dv));
            chk("bus_address", 32'(bus_address), 32'(e.bus));
            chk("map_len", 32'(fmmu_map_address_len), 32'(e.len));
            chk("frame_offset", 32'(fmmu_frame_offset), 32'(e.off));
`ifdef FMMU_HIT_FLAG_EN
            chk("map_hit", 32'(map_hit), 32'(e.hit));
`endif
        end
    end

    localparam logic [31:0] LW = 32'h1414_1414;

    initial begin
        logic [31:0] s, l;
        logic [7:0]  sl, ll;
        int          mode;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        RSTN = 1'b1;
        drive_m(1'b0, 32'h0, 8'h0, LW, 8'd2, 16'h1001);
        drive_m(1'b0, LW, 8'd2, LW, 8'd2, 16'h1001);

        // Misses, overlaps, exact/superset, zero length, wrap
        drive_k(32'h1000_0000, 8'd1, LW, 8'd2, 16'h1001, 16'h0000, 8'd0, 8'd0);
        drive_k(32'h1414_1416, 8'd1, LW, 8'd2, 16'h1001, 16'h0000, 8'd0, 8'd0);
        drive_k(32'h1414_1412, 8'd2, LW, 8'd2, 16'h1001, 16'h0000, 8'd0, 8'd0);
        drive_k(32'h1414_1413, 8'd2, LW, 8'd2, 16'h1001, 16'h1001, 8'd1, 8'd1);
        drive_k(32'h1414_1415, 8'd4, LW, 8'd2, 16'h1001, 16'h1002, 8'd1, 8'd0);
        drive_k(32'h1414_1414, 8'd1, LW, 8'd2, 16'h1001, 16'h1001, 8'd1, 8'd0);
        drive_k(32'h1414_1412, 8'd8, LW, 8'd2, 16'h1001, 16'h1001, 8'd2, 8'd2);
        drive_k(LW, 8'd0, LW, 8'd2, 16'h1001, 16'h0000, 8'd0, 8'd0);
        drive_k(LW, 8'd2, LW, 8'd0, 16'h1001, 16'h0000, 8'd0, 8'd0);
        drive_k(32'hFFFF_FFFF, 8'd1, 32'hFFFF_FFFF, 8'd2, 16'h1001, 16'h1001, 8'd1, 8'd0);
        drive_k(LW + 32'd1, 8'd1, LW, 8'd2, 16'hFFFF, 16'h0000, 8'd1, 8'd0);
        drive_k(32'hFFFF_FFF0, 8'hFF, 32'h0000_0005, 8'd4, 16'h1001, 16'h0000, 8'd0, 8'd0);
        drive_k(32'hFFFF_FFFE, 8'd2, 32'hFFFF_FFFF, 8'd2, 16'h2000, 16'h2000, 8'd1, 8'd1);

        // Asynchronous reset while a result is being held
        drive_k(LW, 8'd2, LW, 8'd2, 16'h1001, 16'h1001, 8'd2, 8'd0);
        @(posedge clk);
        #3;
        RSTN = 1'b0;
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #1;
        chk_zero("held_rst");
        @(negedge clk);
        RSTN = 1'b1;
        subdv = 1'b0;
        sb.push_back('{dv: 1'b0, bus: 16'h0, len: 8'h0, off: 8'h0, hit: 1'b0});
        drive_k(32'h1414_1413, 8'd2, LW, 8'd2, 16'h1001, 16'h1001, 8'd1, 8'd1);
        #1;
        chk("pre_edge_dv", 32'(map_dv), 32'h0);
        drive_m(1'b0, LW, 8'd2, LW, 8'd2, 16'h1001);

        // Random traffic, windows biased to land near each other and near 2^32
        for (int n = 0; n < 400; n++) begin
            mode = $urandom_range(0, 3);
            s  = $urandom;
            if (mode == 3) s = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
            l  = s + 32'($urandom_range(0, 300)) - 32'd150;
            sl = (mode == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
            ll = (mode == 1) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
            drive_m(($urandom_range(0, 7) != 0), s, sl, l, ll, 16'($urandom));
        end
        drive_m(1'b0, 32'h0, 8'h0, 32'h0, 8'h0, 16'h0);

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
